// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the sequential ALU: opcodes, FSM states
//                and the status-flag bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // Packed so the bundle reads as {carry, ovf, neg, zero} on the bus.
    typedef struct packed {
        logic carry;
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Issue/result bus of the sequential ALU. The master is the
//                operand-issue / result-consumer side, the slave is the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    flags_t           flags;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_iter
//  Description : Iterative shift-add multiplier. Consumes one multiplier bit
//                per cycle for WIDTH cycles. done is raised during the final
//                step and product already includes that step's addend.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    input  wire logic [WIDTH-1:0]     a,
    input  wire logic [WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*WIDTH-1:0]        product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

    logic                 r_run;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Accumulator after adding the multiplicand for the current multiplier bit.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign done    = r_run && (r_cnt == c_cnt_last);
    assign product = w_acc_next;

    // Capture operands on start, then shift one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == c_cnt_last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered parametrised ALU with valid/ready handshakes on
//                both sides. Single-cycle ops complete in one edge; MUL is
//                delegated to an iterative multiplier. One op in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_seq_if.slave   bus
);

    state_e             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    flags_t             r_flags;
    logic               r_busy;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_xfer;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_res;
    flags_t             w_flags;
    flags_t             w_mul_flags;

    assign w_in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_mul_start = w_accept && (bus.op == OP_MUL);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.busy      = r_busy;

    // Add/sub carry one extra bit so carry/borrow fall out of the MSB.
    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_shamt = bus.b[SHW-1:0];
    // The extra bit catches the last bit shifted out; a zero shift leaves it 0.
    assign w_shl   = {1'b0, bus.a} << w_shamt;
    assign w_shr   = {bus.a, 1'b0} >> w_shamt;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Flags for a completing multiply; carry marks a truncated upper half.
    always_comb begin
        w_mul_flags       = '0;
        w_mul_flags.carry = |w_product[2*WIDTH-1:WIDTH];
        w_mul_flags.neg   = w_product[WIDTH-1];
        w_mul_flags.zero  = (w_product[WIDTH-1:0] == '0);
    end

    // Single-cycle datapath: result and flags for the op on the input bus.
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (bus.op)
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_ADD: begin
                w_res         = w_sum[WIDTH-1:0];
                w_flags.carry = w_sum[WIDTH];
                w_flags.ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res         = w_diff[WIDTH-1:0];
                w_flags.carry = w_diff[WIDTH];
                w_flags.ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHL: begin
                w_res         = w_shl[WIDTH-1:0];
                w_flags.carry = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res         = w_shr[WIDTH:1];
                w_flags.carry = w_shr[0];
            end
            default: w_res = '0;
        endcase
        w_flags.neg  = w_res[WIDTH-1];
        w_flags.zero = (w_res == '0);
    end

    // Control FSM with registered result, flags, valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.op == OP_MUL) begin
                            r_state     <= MUL;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_result    <= w_res;
                            r_flags     <= w_flags;
                            r_out_valid <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_product[WIDTH-1:0];
                        r_flags     <= w_mul_flags;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one op at the current negedge.
    task automatic drive(input op_e o, input logic [7:0] va, input logic [7:0] vb);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = va;
        bus.b        = vb;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = OP_AND;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++;
        if (bus.result !== 8'h00 || bus.flags !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: result %h flags %b busy %b expected 00 0000 0", bus.result, bus.flags, bus.busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        drive(OP_ADD, 8'hCC, 8'hAA);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h76) begin
            n_fail++; $display("FAIL add_result: valid %b result %h expected 1 76", bus.out_valid, bus.result);
        end
        n_checks++;
        if (bus.flags !== 4'b1100) begin n_fail++; $display("FAIL add_flags: got %b expected 1100", bus.flags); end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: out_valid %b expected 0", bus.out_valid); end
    endtask

    // Back-to-back issue: SUB, SUB, XOR, SHL, SHR with one result per cycle.
    task automatic test_back_to_back();
        op_e        ops  [5] = '{OP_SUB, OP_SUB, OP_XOR, OP_SHL, OP_SHR};
        logic [7:0] va   [5] = '{8'h55, 8'h33, 8'hF0, 8'h81, 8'h01};
        logic [7:0] vb   [5] = '{8'h33, 8'h55, 8'hCC, 8'h01, 8'h01};
        logic [7:0] eres [5] = '{8'h22, 8'hDE, 8'h3C, 8'h02, 8'h00};
        logic [3:0] eflg [5] = '{4'b0000, 4'b1010, 4'b0000, 4'b1000, 4'b1001};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            drive(ops[i], va[i], vb[i]);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== eres[i] || bus.flags !== eflg[i]) begin
                n_fail++;
                $display("FAIL b2b_op[%0d]: valid %b result %h flags %b expected 1 %h %b",
                         i, bus.out_valid, bus.result, bus.flags, eres[i], eflg[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_mul(input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] eres, input logic [3:0] eflg, input string tag);
        drive(OP_MUL, va, vb);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            // Junk on the bus while busy must be ignored; drop it before completion.
            bus.op = OP_ADD;
            bus.a  = 8'h5A;
            bus.b  = 8'hA5;
            bus.in_valid = (i < 7);
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy[%0d]: in_ready %b busy %b out_valid %b expected 0 1 0",
                         tag, i, bus.in_ready, bus.busy, bus.out_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== eres || bus.flags !== eflg) begin
            n_fail++;
            $display("FAIL %s_result: valid %b busy %b result %h flags %b expected 1 0 %h %b",
                     tag, bus.out_valid, bus.busy, bus.result, bus.flags, eres, eflg);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_mul(8'h0F, 8'h11, 8'hFF, 4'b0010, "mul_0f_11");
        run_mul(8'h10, 8'h10, 8'h00, 4'b1001, "mul_10_10");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(OP_ADD, 8'h01, 8'h02);
        @(negedge clk);
        drive(OP_ADD, 8'hFF, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 8'h03 || bus.flags !== 4'b0000 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid %b result %h flags %b in_ready %b expected 1 03 0000 0",
                         i, bus.out_valid, bus.result, bus.flags, bus.in_ready);
            end
            @(negedge clk);
        end
        drive(OP_SUB, 8'h10, 8'h01);
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ready: in_ready %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h0F || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_next: valid %b result %h flags %b expected 1 0f 0000", bus.out_valid, bus.result, bus.flags);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_during_mul();
        int stale;
        drive(OP_MUL, 8'h0F, 8'h11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h00 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL mul_abort: valid %b busy %b result %h flags %b expected 0 0 00 0000",
                     bus.out_valid, bus.busy, bus.result, bus.flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); end
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL abort_stale: %0d cycles with output/busy, expected 0", stale); end
        drive(OP_ADD, 8'h7F, 8'h01);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h80 || bus.flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL post_reset_add: valid %b result %h flags %b expected 1 80 0110", bus.out_valid, bus.result, bus.flags);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_during_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
